// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- bus bundle for the data-memory arbiter.
//   core_* : core load/store port (req/we/addr/wdata in, rdata/stall out)
//   ext_*  : external loader/debug port (req/we/addr/wdata in,
//            gnt/rvalid/rdata out)
//   mem_*  : data memory port (A/WD/WE out, RD combinational in)
// Modports: slave = arbiter view, master = requester/memory environment view.
interface dmem_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;

  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;

  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_A, mem_WD, mem_WE,
    input  mem_RD
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_A, mem_WD, mem_WE,
    output mem_RD
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- single-port data memory arbiter between the core
// load/store unit and an external (loader/debug) master.
// Ports:
//   clk                 : clock, rising edge
//   rst                 : asynchronous reset, active low
//   bus (slave)         : core, ext and memory signals (see dmem_arbiter_if)
//   stat_ext_grants     : count of ext grants (saturating)
//   stat_core_stalls    : count of core stall cycles (saturating)
// Parameter MAX_BURST (1..15): max consecutive ext grants while the core waits.
// Macro DMEM_ARB_STATS_EN: enables the statistics counters; when undefined
// both statistics outputs are constant zero and no counter flops exist.
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        bus,
  output logic [15:0]          stat_ext_grants,
  output logic [15:0]          stat_core_stalls
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    EXT  = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  owner_e      owner_q, owner_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        ext_rvalid_q, ext_rvalid_d;
  logic [31:0] ext_rdata_q, ext_rdata_d;
  logic        core_gnt, ext_gnt;

  // Grant decision; everything is forced idle while reset is held so no
  // access (and in particular no write) can slip through.
  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (rst) begin
      if (bus.core_req && bus.ext_req) begin
        unique case (owner_q)
          IDLE:    core_gnt = 1'b1;
          CORE:    ext_gnt  = 1'b1;
          EXT: begin
            if (burst_cnt_q < MAX_B) ext_gnt  = 1'b1;
            else                     core_gnt = 1'b1;
          end
          default: core_gnt = 1'b1;
        endcase
      end else begin
        core_gnt = bus.core_req;
        ext_gnt  = bus.ext_req;
      end
    end
  end

  always_comb begin
    owner_d      = IDLE;
    burst_cnt_d  = '0;
    ext_rvalid_d = 1'b0;
    ext_rdata_d  = ext_rdata_q;
    if (ext_gnt) begin
      owner_d     = EXT;
      burst_cnt_d = (burst_cnt_q < MAX_B) ? burst_cnt_q + 4'd1 : burst_cnt_q;
      if (!bus.ext_we) begin
        ext_rvalid_d = 1'b1;
        ext_rdata_d  = bus.mem_RD;
      end
    end else if (core_gnt) begin
      owner_d = CORE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= IDLE;
      burst_cnt_q  <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  // Memory port mux: only the grantee's signals reach the memory.
  always_comb begin
    bus.mem_A  = '0;
    bus.mem_WD = '0;
    bus.mem_WE = 1'b0;
    if (ext_gnt) begin
      bus.mem_A  = bus.ext_addr;
      bus.mem_WD = bus.ext_wdata;
      bus.mem_WE = bus.ext_we;
    end else if (core_gnt) begin
      bus.mem_A  = bus.core_addr;
      bus.mem_WD = bus.core_wdata;
      bus.mem_WE = bus.core_we;
    end
  end

  assign bus.core_rdata = bus.mem_RD;
  assign bus.core_stall = rst & bus.core_req & ~core_gnt;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_rdata  = ext_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_ext_q, stat_ext_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_ext_d   = stat_ext_q;
    stat_stall_d = stat_stall_q;
    if (ext_gnt && (stat_ext_q != '1))
      stat_ext_d = stat_ext_q + 16'd1;
    if (bus.core_stall && (stat_stall_q != '1))
      stat_stall_d = stat_stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ext_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ext_q   <= stat_ext_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ext_grants  = stat_ext_q;
  assign stat_core_stalls = stat_stall_q;
`else
  assign stat_ext_grants  = '0;
  assign stat_core_stalls = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- self-checking bench for dmem_arbiter: directed
// scenarios followed by randomized traffic against a behavioural model.
module tb_dmem_arbiter;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] stat_ext_grants;
  logic [15:0] stat_core_stalls;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_BURST(MB)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .stat_ext_grants  (stat_ext_grants),
    .stat_core_stalls (stat_core_stalls)
  );

  always #5 clk = ~clk;

  // Small word-addressed data memory, combinational read.
  logic [31:0] bmem [16];
  assign bus.mem_RD = bmem[bus.mem_A[5:2]];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who was served last, how long the current ext run is,
  // pending read return and statistic totals.
  int          m_last;   // 0 nobody, 1 core, 2 ext
  int          m_run;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  int          m_sx, m_ss;

  logic [11:0] gseq;
  int          gidx;
  bit          rec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed);
    bus.core_req   = cr;
    bus.core_we    = cw;
    bus.core_addr  = ca;
    bus.core_wdata = cd;
    bus.ext_req    = er;
    bus.ext_we     = ew;
    bus.ext_addr   = ea;
    bus.ext_wdata  = ed;
  endtask

  task automatic model_reset();
    m_last   = 0;
    m_run    = 0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_sx     = 0;
    m_ss     = 0;
  endtask

  function automatic logic [31:0] exp_sx();
`ifdef DMEM_ARB_STATS_EN
    return 32'(m_sx);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_ss();
`ifdef DMEM_ARB_STATS_EN
    return 32'(m_ss);
`else
    return 32'd0;
`endif
  endfunction

  // Start at a negedge with inputs already driven; checks this cycle's
  // outputs, advances the model across the posedge, ends at next negedge.
  task automatic cycle();
    int          g;
    logic [31:0] ea, ed, rd;
    logic        ewe;
    #2;
    if (bus.core_req && bus.ext_req) begin
      if (m_last == 1)                    g = 2;
      else if (m_last == 2 && m_run < MB) g = 2;
      else                                g = 1;
    end else if (bus.core_req) g = 1;
    else if (bus.ext_req)      g = 2;
    else                       g = 0;

    ea  = (g == 1) ? bus.core_addr  : (g == 2) ? bus.ext_addr  : 32'd0;
    ed  = (g == 1) ? bus.core_wdata : (g == 2) ? bus.ext_wdata : 32'd0;
    ewe = (g == 1) ? bus.core_we    : (g == 2) ? bus.ext_we    : 1'b0;
    rd  = bmem[ea[5:2]];

    check("ext_gnt",    32'(bus.ext_gnt),    32'(g == 2));
    check("core_stall", 32'(bus.core_stall), 32'(bus.core_req && g != 1));
    check("mem_A",      bus.mem_A,           ea);
    check("mem_WD",     bus.mem_WD,          ed);
    check("mem_WE",     32'(bus.mem_WE),     32'(ewe));
    check("core_rdata", bus.core_rdata,      rd);
    check("ext_rvalid", 32'(bus.ext_rvalid), 32'(m_rvalid));
    check("ext_rdata",  bus.ext_rdata,       m_rdata);
    check("stat_ext",   32'(stat_ext_grants),  exp_sx());
    check("stat_stall", 32'(stat_core_stalls), exp_ss());

    if (rec && gidx < 12) begin
      gseq[gidx] = bus.ext_gnt;
      gidx++;
    end

    @(posedge clk);
    m_rvalid = (g == 2) && !bus.ext_we;
    if (m_rvalid) m_rdata = rd;
    if (g == 2 && m_sx < 65535) m_sx++;
    if (bus.core_req && g != 1 && m_ss < 65535) m_ss++;
    m_run  = (g == 2) ? ((m_run < MB) ? m_run + 1 : m_run) : 0;
    m_last = g;
    #1;
    if (ewe) bmem[ea[5:2]] = ed;
    @(negedge clk);
  endtask

  // Hold reset for one full cycle with every request (including writes)
  // active; nothing may be granted or written meanwhile.
  task automatic do_reset();
    drive(1'b1, 1'b1, 32'h14, 32'h0000FFFF, 1'b1, 1'b1, 32'h18, 32'h00001234);
    rst = 1'b0;
    model_reset();
    #2;
    check("rst_ext_gnt",    32'(bus.ext_gnt),    32'd0);
    check("rst_core_stall", 32'(bus.core_stall), 32'd0);
    check("rst_mem_WE",     32'(bus.mem_WE),     32'd0);
    check("rst_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
    check("rst_ext_rdata",  bus.ext_rdata,       32'd0);
    check("rst_stat_ext",   32'(stat_ext_grants),  32'd0);
    check("rst_stat_stall", 32'(stat_core_stalls), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) bmem[i] = 32'h1000_0000 + 32'(i);
    rec  = 1'b0;
    gidx = 0;
    gseq = '0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    model_reset();

    @(negedge clk);
    do_reset();

    // Core-only store to 0x10.
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle();

    // Ext-only read of 0x10; data returns the following cycle.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0);
    cycle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("ext_read_rvalid", 32'(bus.ext_rvalid), 32'd1);
    check("ext_read_rdata",  bus.ext_rdata,       32'hDEADBEEF);
    cycle();

    // Continuous dual requests from IDLE for 12 cycles.
    do_reset();
    rec  = 1'b1;
    gidx = 0;
    drive(1'b1, 1'b0, 32'h20, 32'd0, 1'b1, 1'b0, 32'h24, 32'd0);
    repeat (12) cycle();
    rec = 1'b0;
    check("dual_grant_seq", 32'(gseq), 32'h0000_0BDE);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
`ifdef DMEM_ARB_STATS_EN
    check("dual_stat_ext",   32'(stat_ext_grants),  32'd9);
    check("dual_stat_stall", 32'(stat_core_stalls), 32'd9);
`else
    check("dual_stat_ext",   32'(stat_ext_grants),  32'd0);
    check("dual_stat_stall", 32'(stat_core_stalls), 32'd0);
`endif
    cycle();

    // Ext read granted, then reset asserted before the capturing edge.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0);
    #2;
    check("rstmid_gnt_before", 32'(bus.ext_gnt), 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid_gnt_during", 32'(bus.ext_gnt), 32'd0);
    check("rstmid_mem_WE",     32'(bus.mem_WE),  32'd0);
    @(posedge clk);
    #1;
    check("rstmid_rvalid", 32'(bus.ext_rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    // First cycle after reset: dual request must go to the core.
    drive(1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b0, 32'h0C, 32'd0);
    cycle();

    // Randomized traffic, biased toward contention, with rare resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
